// File: rtl/hardcopyii_pll_scan_ctrl_if.sv
// Handshake bundle between the PLL reconfiguration logic (master) and the
// scan-chain controller (slave).
interface hardcopyii_pll_scan_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] wdata;
  logic         hold;
  logic         busy;
  logic         done;
  logic [W-1:0] rdata;

  modport master (
    output start,
    output wdata,
    output hold,
    input  busy,
    input  done,
    input  rdata
  );

  modport slave (
    input  start,
    input  wdata,
    input  hold,
    output busy,
    output done,
    output rdata
  );
endinterface

// File: rtl/hardcopyii_pll_scan_ctrl.sv
// PLL reconfiguration scan-chain controller: shifts a W-bit word into the
// chain head (MSB first) while capturing the word falling out of the tail.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; rdata holds the last captured word
// ST_SHIFT | one chain shift per cycle unless hold is high
// ST_DONE  | single-cycle done pulse, then back to idle
module hardcopyii_pll_scan_ctrl #(
  parameter int W = 16
) (
  input  logic                        clk,
  input  logic                        clrn,
  hardcopyii_pll_scan_ctrl_if.slave   bus,
  input  logic                        scandataout,
  output logic                        scandata,
  output logic                        scanena
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic [W-1:0]  shifted;

  // Shift word: the tail bit enters at the LSB so the first bit out of the
  // chain ends up in the MSB after W shifts.
  assign shifted = {sreg_q[W-2:0], scandataout};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.wdata;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bus.hold) begin
          sreg_d = shifted;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            rdata_d = shifted;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register bank; reset clears everything, including the captured word.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Chain enable follows hold combinationally so chain and controller
  // stall on the same edge and never slip relative to each other.
  assign scanena   = (state_q == ST_SHIFT) & ~bus.hold;
  assign scandata  = sreg_q[W-1];
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_hardcopyii_pll_scan_ctrl.sv
// Bench for hardcopyii_pll_scan_ctrl with a behavioural W-bit scan chain.
module tb_hardcopyii_pll_scan_ctrl;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] rdata;
    logic [W-1:0] chain;
    int           done_idx;
  } exp_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic scandata, scanena, scandataout;
  logic [W-1:0] chain;
  logic preload_en = 1'b0;
  logic [W-1:0] preload_val = '0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  hardcopyii_pll_scan_ctrl_if #(.W(W)) bus ();

  hardcopyii_pll_scan_ctrl #(.W(W)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .bus         (bus),
    .scandataout (scandataout),
    .scandata    (scandata),
    .scanena     (scanena)
  );

  always #5 clk = ~clk;

  // Model of the enable-gated PLL scan chain.
  always @(posedge clk) begin
    if (preload_en) chain <= preload_val;
    else if (scanena) chain <= {chain[W-2:0], scandata};
  end
  assign scandataout = chain[W-1];

  task automatic preload(input logic [W-1:0] v);
    @(negedge clk);
    preload_val = v;
    preload_en  = 1'b1;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // Runs one pass starting from a negedge phase; the scoreboard entry is
  // pushed when start is driven and checked when done appears.
  task automatic do_pass(input logic [W-1:0] wd, input int hold_at, input int hold_len,
                         input bit reint, input logic [W-1:0] rwd,
                         input bit keep_start, input logic [W-1:0] next_wd);
    exp_t e;
    int ena_cnt;
    bit got;
    ena_cnt = 0;
    got = 1'b0;
    e.rdata = chain;
    e.chain = wd;
    e.done_idx = W + hold_len;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.wdata = wd;
    @(posedge clk);
    for (int i = 0; i < W + 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (keep_start) bus.wdata = next_wd;
        else bus.start = 1'b0;
      end
      if (reint && i == 3) begin bus.start = 1'b1; bus.wdata = rwd; end
      if (reint && i == 4) bus.start = 1'b0;
      bus.hold = (hold_len > 0) && (i >= hold_at) && (i < hold_at + hold_len);
      #1;
      if (scanena) ena_cnt++;
      if (bus.done) begin
        got = 1'b1;
        e = sb.pop_front();
        compared += 5;
        if (bus.rdata !== e.rdata) begin
          mismatched++;
          $display("FAIL pass_rdata: got %h expected %h", bus.rdata, e.rdata);
        end
        if (chain !== e.chain) begin
          mismatched++;
          $display("FAIL pass_chain: got %h expected %h", chain, e.chain);
        end
        if (i != e.done_idx) begin
          mismatched++;
          $display("FAIL done_latency: got %0d expected %0d", i, e.done_idx);
        end
        if (ena_cnt != W) begin
          mismatched++;
          $display("FAIL scanena_cycles: got %0d expected %0d", ena_cnt, W);
        end
        if (bus.busy !== 1'b1 || scanena !== 1'b0) begin
          mismatched++;
          $display("FAIL done_cycle: busy %b scanena %b expected busy 1 scanena 0",
                   bus.busy, scanena);
        end
      end
    end
    bus.hold = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL pass_timeout: no done within budget, expected at index %0d", e.done_idx);
      void'(sb.pop_front());
    end
  endtask

  // Checks the cycle right after done: pulse gone, controller idle.
  task automatic check_after_done(input string name);
    @(negedge clk);
    #1;
    compared++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || scanena !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: done %b busy %b scanena %b expected 0 0 0",
               name, bus.done, bus.busy, scanena);
    end
  endtask

  task automatic test_reset();
    int ena_seen;
    ena_seen = 0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.wdata = '0;
    clrn = 1'b0;
    #3;
    compared++;
    if ({scandata, scanena, bus.busy, bus.done, bus.rdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b%b%b%b %h expected all 0",
               scandata, scanena, bus.busy, bus.done, bus.rdata);
    end
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (scanena !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) ena_seen++;
    end
    compared++;
    if (ena_seen != 0 || bus.rdata !== '0) begin
      mismatched++;
      $display("FAIL reset_idle: active cycles %0d rdata %h expected 0 and 0",
               ena_seen, bus.rdata);
    end
  endtask

  task automatic test_basic();
    preload(16'hA5C3);
    do_pass(16'h1234, 0, 0, 1'b0, '0, 1'b0, '0);
    check_after_done("basic_after_done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    do_pass(16'hFFFF, 0, 0, 1'b0, '0, 1'b1, 16'h0001);
    @(negedge clk);
    #1;
    compared++;
    if (bus.busy !== 1'b0 || scanena !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_idle_gap: busy %b scanena %b done %b expected 0 0 0",
               bus.busy, scanena, bus.done);
    end
    do_pass(16'h0001, 0, 0, 1'b0, '0, 1'b0, '0);
    check_after_done("b2b_after_done");
  endtask

  task automatic test_hold();
    @(negedge clk);
    do_pass(16'hBEEF, 5, 3, 1'b0, '0, 1'b0, '0);
    check_after_done("hold_after_done");
  endtask

  task automatic test_start_busy();
    int active;
    active = 0;
    @(negedge clk);
    do_pass(16'hC3A1, 0, 0, 1'b1, 16'h0F0F, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || scanena !== 1'b0) active++;
    end
    compared++;
    if (active != 0) begin
      mismatched++;
      $display("FAIL start_busy_not_queued: active cycles %0d expected 0", active);
    end
  endtask

  task automatic test_reset_midpass();
    int shifts;
    bit hit;
    shifts = 0;
    hit = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.wdata = 16'h3C3C;
    @(posedge clk);
    for (int i = 0; i < W + 5 && !hit; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (shifts == 7) begin
        hit = 1'b1;
        clrn = 1'b0;
        #1;
        compared++;
        if (scanena !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== '0 ||
            bus.done !== 1'b0 || scandata !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_midpass: scanena %b busy %b done %b scandata %b rdata %h expected 0",
                   scanena, bus.busy, bus.done, scandata, bus.rdata);
        end
      end else begin
        #1;
        if (scanena) shifts++;
      end
    end
    if (!hit) begin
      compared++;
      mismatched++;
      $display("FAIL reset_midpass_timeout: shifts %0d expected 7", shifts);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    do_pass(16'h5555, 0, 0, 1'b0, '0, 1'b0, '0);
    check_after_done("reset_recovery_after_done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_start_busy();
    test_reset_midpass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hardcopyii_pll_scan_ctrl.md
# hardcopyii_pll_scan_ctrl

Serial scan-chain controller that writes a W-bit configuration word into a PLL reconfiguration scan chain and reads back the chain's previous contents in the same pass. It is the writer/reader on the far side of the chain built from enable-gated PLL scan registers. It is driven by the reconfiguration logic through a start/busy/done handshake. Chain registers share `clk` and shift only when `scanena` is high.

## Interface
Parameters:
- `W`, default 16: scan chain length in bits; legal range 2..1024.

Ports:
- `clk`  in  1: single clock, rising-edge active.
- `clrn`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a scan pass; sampled only in IDLE.
- `wdata`  in  W: configuration word, MSB shifted first; sampled with `start`.
- `hold`  in  1: pause shifting while high during SHIFT.
- `scandataout`  in  1: serial output (tail) of the PLL scan chain.
- `scandata`  out  1: serial data into the chain head.
- `scanena`  out  1: chain shift enable.
- `busy`  out  1: pass in progress.
- `done`  out  1: one-cycle completion pulse.
- `rdata`  out  W: chain contents captured during the last completed pass.

## Operation
- States: IDLE, SHIFT, DONE. The state, shift register `sreg[W-1:0]`, counter `cnt` (ceil(log2(W+1)) bits), `busy`, `done` and `rdata` are registers. Reset (`clrn`=0) forces all of them to 0 immediately, and the state to IDLE.
- `scandata` = `sreg[W-1]`.
- `scanena` = (state==SHIFT) & ~`hold`. This is the only combinational output.
- IDLE: on an edge with `start`=1:
  - `sreg`<=`wdata`, `cnt`<=0, state->SHIFT, `busy`<=1.
  - `start`=0 means no change.
- SHIFT, edge with `hold`=0:
  - `sreg`<={`sreg[W-2:0]`, `scandataout`}, `cnt`<=`cnt`+1.
  - If `cnt`==W-1: state->DONE, `rdata`<={`sreg[W-2:0]`, `scandataout`}, `done`<=1.
- SHIFT, edge with `hold`=1: nothing changes. `scanena` is 0 for that cycle, so the chain also holds. Chain and controller stay aligned bit-for-bit.
- DONE: next edge clears `done` and `busy`, and sets state->IDLE. `hold` is ignored in DONE.
- `start` while `busy`=1 is ignored. It is not queued.
- `wdata` changes after the start edge have no effect on the pass in progress.
- `rdata` changes only at DONE entry and holds between passes.
- The bit first emerging on `scandataout` lands in `rdata[W-1]`. Writing word A and then word B returns A in `rdata` at the end of the B pass.
- Reset mid-SHIFT:
  - `scanena` drops asynchronously; the chain is left partially shifted.
  - `rdata` reads 0.
  - No recovery is attempted; the next `start` performs a full W-bit pass.

## Timing
- Start edge E0. With `hold`=0, `scanena`=1 in cycles E0..E_{W-1}. This is exactly W chain shifts, at edges E1..E_W.
- `done`=1 and `scanena`=0 in the cycle after E_W. `busy`=1 from E0 through the DONE cycle, which is W+1 cycles.
- Each `hold` cycle in SHIFT extends `busy` and the `done` latency by one cycle.
- The earliest next start edge is E_{W+1}, the edge that leaves DONE. It is ignored because the state is still DONE at that edge. The first accepted start is E_{W+2}.
- Reset values: `scandata`=0, `scanena`=0, `busy`=0, `done`=0, `rdata`=0.

## Test plan
- Reset, then idle: with `clrn` low, then high for 5 cycles -> all outputs 0 and `scanena` never asserts.
- Basic write, W=16, chain model preloaded 0xA5C3, `wdata`=0x1234, `start` pulse:
  - `scanena` high for exactly 16 cycles; `done` pulses on cycle 17.
  - Chain model holds 0x1234 and `rdata`=0xA5C3.
- Back-to-back passes: pass 0xFFFF, then 0x0001 -> second pass returns `rdata`=0xFFFF and chain=0x0001. A `start` held high continuously yields passes separated by one IDLE cycle.
- Hold: `hold` high for 3 cycles mid-pass (after 5 shifts) with `wdata`=0xBEEF:
  - `scanena` low for those 3 cycles; `done` arrives 3 cycles later.
  - Chain=0xBEEF with no duplicated or lost bits.
- `start` re-asserted while busy with `wdata`=0x0F0F -> ignored; the pass completes with the original word.
- Reset asserted after 7 shifts -> `scanena`, `busy` and `rdata` go to 0 immediately. A fresh pass of 0x5555 then leaves chain=0x5555.
